// File: rtl/mastermind_engine.sv
// Mastermind scoring core: latches the secret code, accepts guesses over valid/ready and scores
// them one colour per cycle. Define MM_HISTORY_EN to keep a per-turn {guess, exact, partial} history.
module mastermind_engine #(
  parameter int PEGS      = 4,
  parameter int COLOR_W   = 3,
  parameter int MAX_TURNS = 8,
  parameter int TURN_W    = $clog2(MAX_TURNS + 1),
  parameter int CNT_W     = $clog2(PEGS + 1)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    new_game,
  input  logic [PEGS*COLOR_W-1:0] code,
  input  logic                    guess_valid,
  input  logic [PEGS*COLOR_W-1:0] guess,
  output logic                    guess_ready,
  output logic                    score_valid,
  output logic [CNT_W-1:0]        exact,
  output logic [CNT_W-1:0]        partial,
  output logic [TURN_W-1:0]       turn_count,
  output logic                    game_over,
  output logic                    win,
  input  logic [TURN_W-1:0]       hist_sel,
  output logic [PEGS*COLOR_W-1:0] hist_guess,
  output logic [CNT_W-1:0]        hist_exact,
  output logic [CNT_W-1:0]        hist_partial
);

  // state  | meaning
  // IDLE   | after reset, waiting for new_game
  // WAIT   | ready for a guess
  // SCORE  | accumulating min(code count, guess count) per colour
  // REPORT | score_valid pulse, turn/win/game_over update
  // DONE   | game finished, waiting for new_game
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_SCORE, S_REPORT, S_DONE} state_t;

  localparam int CW = PEGS * COLOR_W;

  state_t             state_q, state_d;
  logic [CW-1:0]      code_q, guess_q;
  logic [COLOR_W-1:0] col_q;
  logic [CNT_W-1:0]   sum_q, sum_next, exact_acc_q, exact_q, partial_q, exact_new;
  logic [CNT_W-1:0]   cnt_code, cnt_guess, min_cnt;
  logic [TURN_W-1:0]  turn_q;
  logic               game_over_q, win_q;
  logic               last_col;

  assign last_col   = &col_q;
  assign exact      = exact_q;
  assign partial    = partial_q;
  assign turn_count = turn_q;
  assign game_over  = game_over_q;
  assign win        = win_q;

  always_comb begin
    exact_new = '0;
    for (int p = 0; p < PEGS; p++)
      if (guess[p*COLOR_W +: COLOR_W] == code_q[p*COLOR_W +: COLOR_W])
        exact_new = exact_new + CNT_W'(1);
  end

  always_comb begin
    cnt_code  = '0;
    cnt_guess = '0;
    for (int p = 0; p < PEGS; p++) begin
      if (code_q[p*COLOR_W +: COLOR_W] == col_q)  cnt_code  = cnt_code + CNT_W'(1);
      if (guess_q[p*COLOR_W +: COLOR_W] == col_q) cnt_guess = cnt_guess + CNT_W'(1);
    end
    min_cnt  = (cnt_code < cnt_guess) ? cnt_code : cnt_guess;
    sum_next = sum_q + min_cnt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    guess_ready = 1'b0;
    score_valid = 1'b0;
    case (state_q)
      S_IDLE: ;
      S_WAIT: begin
        guess_ready = 1'b1;
        if (guess_valid) state_d = S_SCORE;
      end
      S_SCORE: if (last_col) state_d = S_REPORT;
      S_REPORT: begin
        score_valid = 1'b1;
        if (exact_q == CNT_W'(PEGS) || (turn_q + TURN_W'(1)) == TURN_W'(MAX_TURNS))
          state_d = S_DONE;
        else
          state_d = S_WAIT;
      end
      S_DONE: ;
      default: state_d = S_IDLE;
    endcase
    // new_game overrides everything, including a guess offered in the same cycle
    if (new_game) state_d = S_WAIT;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      code_q      <= '0;
      guess_q     <= '0;
      col_q       <= '0;
      sum_q       <= '0;
      exact_acc_q <= '0;
      exact_q     <= '0;
      partial_q   <= '0;
      turn_q      <= '0;
      game_over_q <= 1'b0;
      win_q       <= 1'b0;
    end else if (new_game) begin
      code_q      <= code;
      turn_q      <= '0;
      game_over_q <= 1'b0;
      win_q       <= 1'b0;
      exact_q     <= '0;
      partial_q   <= '0;
    end else begin
      case (state_q)
        S_WAIT: if (guess_valid) begin
          guess_q     <= guess;
          exact_acc_q <= exact_new;
          col_q       <= '0;
          sum_q       <= '0;
        end
        S_SCORE: begin
          col_q <= col_q + COLOR_W'(1);
          sum_q <= sum_next;
          // publish both counts together so they are valid during the REPORT pulse
          if (last_col) begin
            exact_q   <= exact_acc_q;
            partial_q <= sum_next - exact_acc_q;
          end
        end
        S_REPORT: begin
          turn_q <= turn_q + TURN_W'(1);
          if (exact_q == CNT_W'(PEGS)) begin
            win_q       <= 1'b1;
            game_over_q <= 1'b1;
          end else if ((turn_q + TURN_W'(1)) == TURN_W'(MAX_TURNS)) begin
            game_over_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MM_HISTORY_EN
  localparam int HIDX_W = (MAX_TURNS > 1) ? $clog2(MAX_TURNS) : 1;

  logic [CW-1:0]    hg_q [MAX_TURNS];
  logic [CNT_W-1:0] he_q [MAX_TURNS];
  logic [CNT_W-1:0] hp_q [MAX_TURNS];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MAX_TURNS; i++) begin
        hg_q[i] <= '0;
        he_q[i] <= '0;
        hp_q[i] <= '0;
      end
    end else if (new_game) begin
      for (int i = 0; i < MAX_TURNS; i++) begin
        hg_q[i] <= '0;
        he_q[i] <= '0;
        hp_q[i] <= '0;
      end
    end else if (state_q == S_REPORT) begin
      hg_q[turn_q[HIDX_W-1:0]] <= guess_q;
      he_q[turn_q[HIDX_W-1:0]] <= exact_q;
      hp_q[turn_q[HIDX_W-1:0]] <= partial_q;
    end
  end

  always_comb begin
    hist_guess   = '0;
    hist_exact   = '0;
    hist_partial = '0;
    if (hist_sel < turn_q) begin
      hist_guess   = hg_q[hist_sel[HIDX_W-1:0]];
      hist_exact   = he_q[hist_sel[HIDX_W-1:0]];
      hist_partial = hp_q[hist_sel[HIDX_W-1:0]];
    end
  end
`else
  logic unused_hist_sel;
  assign unused_hist_sel = ^hist_sel;
  assign hist_guess      = '0;
  assign hist_exact      = '0;
  assign hist_partial    = '0;
`endif

endmodule

// File: tb/tb_mastermind_engine.sv
// Directed bench for mastermind_engine with a score scoreboard (expected exact/partial/cycle queue).
module tb_mastermind_engine;
  localparam int PEGS = 4, COLOR_W = 3, MAX_TURNS = 8;
  localparam int TURN_W = $clog2(MAX_TURNS + 1), CNT_W = $clog2(PEGS + 1);
  localparam int CW = PEGS * COLOR_W;
  localparam int LAT = (1 << COLOR_W) + 1;

  logic              clk = 1'b0, reset_n = 1'b0, new_game = 1'b0, guess_valid = 1'b0;
  logic [CW-1:0]     code = '0, guess = '0;
  logic [TURN_W-1:0] hist_sel = '0;
  logic              guess_ready, score_valid, game_over, win;
  logic [CNT_W-1:0]  exact, partial, hist_exact, hist_partial;
  logic [TURN_W-1:0] turn_count;
  logic [CW-1:0]     hist_guess;

  mastermind_engine #(.PEGS(PEGS), .COLOR_W(COLOR_W), .MAX_TURNS(MAX_TURNS)) dut (
    .clk(clk), .reset_n(reset_n), .new_game(new_game), .code(code),
    .guess_valid(guess_valid), .guess(guess), .guess_ready(guess_ready),
    .score_valid(score_valid), .exact(exact), .partial(partial),
    .turn_count(turn_count), .game_over(game_over), .win(win),
    .hist_sel(hist_sel), .hist_guess(hist_guess), .hist_exact(hist_exact),
    .hist_partial(hist_partial));

  always #5 clk = ~clk;

  typedef struct { int ex; int pa; int cyc; } exp_t;
  exp_t sb[$];
  int   total = 0, bad = 0, cyc = 0, sv_count = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic logic [CW-1:0] pack4(input int a, input int b, input int c, input int d);
    return {3'(d), 3'(c), 3'(b), 3'(a)};
  endfunction

  // Reference scorer: mark exact pegs, then pair each leftover guess peg with a leftover code peg.
  function automatic void model(input logic [CW-1:0] c, input logic [CW-1:0] g,
                                output int ex, output int pa);
    bit cu[PEGS], gu[PEGS];
    ex = 0; pa = 0;
    for (int p = 0; p < PEGS; p++) begin
      cu[p] = 0; gu[p] = 0;
      if (c[p*COLOR_W +: COLOR_W] == g[p*COLOR_W +: COLOR_W]) begin
        ex++; cu[p] = 1; gu[p] = 1;
      end
    end
    for (int i = 0; i < PEGS; i++) begin
      if (!gu[i]) begin
        for (int j = 0; j < PEGS; j++) begin
          if (!cu[j] && g[i*COLOR_W +: COLOR_W] == c[j*COLOR_W +: COLOR_W]) begin
            cu[j] = 1; pa++; break;
          end
        end
      end
    end
  endfunction

  always @(negedge clk) begin
    if (reset_n && score_valid) begin
      exp_t e;
      sv_count++;
      if (sb.size() == 0) begin
        chk("unexpected_score", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("exact", 32'(exact), 32'(e.ex));
        chk("partial", 32'(partial), 32'(e.pa));
        chk("latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic start(input logic [CW-1:0] c);
    @(negedge clk); new_game = 1'b1; code = c;
    @(negedge clk); new_game = 1'b0;
  endtask

  // offers a guess, pushes the expected score, waits for it; returns at the negedge after REPORT
  task automatic play(input logic [CW-1:0] g);
    int ex, pa;
    bit got;
    @(negedge clk); guess_valid = 1'b1; guess = g;
    got = 0;
    for (int k = 0; k < 20; k++) begin
      if (guess_ready) begin got = 1; break; end
      @(negedge clk);
    end
    if (!got) begin
      chk("ready_timeout", 32'(guess_ready), 32'd1);
      guess_valid = 1'b0;
      return;
    end
    model(code, g, ex, pa);
    sb.push_back('{ex: ex, pa: pa, cyc: cyc + LAT});
    @(negedge clk); guess_valid = 1'b0;
    got = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk); #1;
      if (sb.size() == 0) begin got = 1; break; end
    end
    if (!got) begin
      chk("score_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int sv0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(guess_ready), 0);
    chk("rst_sv", 32'(score_valid), 0);
    chk("rst_exact", 32'(exact), 0);
    chk("rst_turn", 32'(turn_count), 0);
    chk("rst_over", 32'(game_over), 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", 32'(guess_ready), 0);

    // immediate win
    start(pack4(1, 2, 3, 4));
    chk("wait_ready", 32'(guess_ready), 1);
    play(pack4(1, 2, 3, 4));
    chk("win1_win", 32'(win), 1);
    chk("win1_over", 32'(game_over), 1);
    chk("win1_turn", 32'(turn_count), 1);
    chk("win1_ready", 32'(guess_ready), 0);

    // all partial
    start(pack4(1, 2, 3, 4));
    play(pack4(4, 3, 2, 1));
    chk("perm_over", 32'(game_over), 0);
    chk("perm_ready", 32'(guess_ready), 1);
    chk("perm_turn", 32'(turn_count), 1);
    chk("perm_hold_pa", 32'(partial), 4);

    // duplicates
    start(pack4(1, 1, 2, 2));
    play(pack4(1, 2, 1, 0));
    play(pack4(5, 5, 5, 5));
    chk("dup_turn", 32'(turn_count), 2);

    // turns exhausted
    start(pack4(1, 2, 3, 4));
    for (int i = 0; i < MAX_TURNS; i++) play(pack4(i, 0, 7, 7 - i));
    chk("lose_over", 32'(game_over), 1);
    chk("lose_win", 32'(win), 0);
    chk("lose_turn", 32'(turn_count), MAX_TURNS);
    sv0 = sv_count;
    @(negedge clk); guess_valid = 1'b1; guess = pack4(1, 2, 3, 4);
    repeat (3) @(negedge clk);
    chk("ninth_ready", 32'(guess_ready), 0);
    repeat (12) @(negedge clk);
    guess_valid = 1'b0;
    chk("ninth_noscore", 32'(sv_count), 32'(sv0));
    chk("ninth_turn", 32'(turn_count), MAX_TURNS);

    // win on the final turn
    start(pack4(6, 5, 4, 3));
    for (int i = 0; i < MAX_TURNS - 1; i++) play(pack4(3, 4, 5, i));
    play(pack4(6, 5, 4, 3));
    chk("last_win", 32'(win), 1);
    chk("last_over", 32'(game_over), 1);
    chk("last_turn", 32'(turn_count), MAX_TURNS);

    // new_game aborts mid-SCORE
    start(pack4(2, 2, 2, 2));
    play(pack4(2, 0, 0, 0));
    sv0 = sv_count;
    @(negedge clk); guess_valid = 1'b1; guess = pack4(2, 2, 0, 0);
    @(negedge clk); guess_valid = 1'b0;
    repeat (3) @(negedge clk);
    new_game = 1'b1; code = pack4(7, 7, 7, 7);
    @(negedge clk); new_game = 1'b0;
    repeat (12) @(negedge clk);
    chk("abort_noscore", 32'(sv_count), 32'(sv0));
    chk("abort_turn", 32'(turn_count), 0);
    chk("abort_ready", 32'(guess_ready), 1);
    chk("abort_exact", 32'(exact), 0);
    play(pack4(7, 0, 7, 0));

    // async reset mid-SCORE
    start(pack4(1, 2, 3, 4));
    play(pack4(1, 2, 4, 3));
    @(negedge clk); guess_valid = 1'b1; guess = pack4(1, 1, 1, 1);
    @(negedge clk); guess_valid = 1'b0;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_exact", 32'(exact), 0);
    chk("arst_partial", 32'(partial), 0);
    chk("arst_turn", 32'(turn_count), 0);
    chk("arst_ready", 32'(guess_ready), 0);
    chk("arst_sv", 32'(score_valid), 0);
    @(negedge clk); reset_n = 1'b1;
    sv0 = sv_count;
    @(negedge clk);
    new_game = 1'b1; code = pack4(1, 2, 3, 4); guess_valid = 1'b1; guess = pack4(1, 2, 3, 4);
    @(negedge clk); new_game = 1'b0; guess_valid = 1'b0;
    chk("ng_gv_ready", 32'(guess_ready), 1);
    chk("ng_gv_turn", 32'(turn_count), 0);
    repeat (12) @(negedge clk);
    chk("ng_gv_noscore", 32'(sv_count), 32'(sv0));

    // history readback
    start(pack4(1, 2, 3, 4));
    play(pack4(4, 3, 2, 1));
    play(pack4(1, 1, 1, 1));
`ifdef MM_HISTORY_EN
    hist_sel = 1; #1;
    chk("hist1_guess", 32'(hist_guess), 32'(pack4(1, 1, 1, 1)));
    chk("hist1_exact", 32'(hist_exact), 1);
    chk("hist1_partial", 32'(hist_partial), 0);
    hist_sel = 0; #1;
    chk("hist0_guess", 32'(hist_guess), 32'(pack4(4, 3, 2, 1)));
    chk("hist0_partial", 32'(hist_partial), 4);
    hist_sel = 5; #1;
    chk("hist5_guess", 32'(hist_guess), 0);
    chk("hist5_exact", 32'(hist_exact), 0);
`else
    hist_sel = 1; #1;
    chk("nohist_guess", 32'(hist_guess), 0);
    chk("nohist_exact", 32'(hist_exact), 0);
    chk("nohist_partial", 32'(hist_partial), 0);
`endif
    hist_sel = 0;
    chk("sb_empty", 32'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=timeout expected=finish");
    $fatal(1, "bench timed out");
  end
endmodule
